fifo_burst_reader: RTL and testbench

Consumer for the team's show-ahead register FIFO: drains a programmed burst of words from the FIFO read port (`notempty` / `fifodout` / `fiford`) and presents them as a framed valid/ready stream with start-of-packet and end-of-packet marks. It sits between a FIFO instance and a downstream packet engine and sustains one word per cycle when both sides allow. A control handshake (`start`, `busy`, `done`) sequences one burst at a time.

---
 rtl/fifo_burst_pkg.sv | 12 +
 rtl/fifo_burst_reader_if.sv | 35 +++
 rtl/fifo_burst_reader.sv | 120 ++++++++++++
 tb/tb_fifo_burst_reader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_pkg.sv
// Shared constants for the show-ahead FIFO and its burst reader.
// Holds the FSM state encoding and the default word/length widths.
package fifo_burst_pkg;

  localparam int FIFO_WIDTH  = 8;
  localparam int FIFO_LENBIT = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Bundles the FIFO read port, burst control handshake and framed output stream.
// slave is the reader's view; master is the environment driving it.
interface fifo_burst_reader_if
  import fifo_burst_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int LENBIT = FIFO_LENBIT
);

  logic              notempty;
  logic [WIDTH-1:0]  fifodout;
  logic              fiford;

  logic              start;
  logic [LENBIT-1:0] burstlen;
  logic              busy;
  logic              done;

  logic              ovld;
  logic [WIDTH-1:0]  odat;
  logic              osop;
  logic              oeop;
  logic              ordy;

  modport master (
    output notempty, fifodout, start, burstlen, ordy,
    input  fiford, busy, done, ovld, odat, osop, oeop
  );

  modport slave (
    input  notempty, fifodout, start, burstlen, ordy,
    output fiford, busy, done, ovld, odat, osop, oeop
  );

endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a programmed burst from a show-ahead FIFO into a framed valid/ready
// stream, one word per cycle when both sides allow.
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int LENBIT = FIFO_LENBIT
)
(
  input logic                clk,
  input logic                rst_,
  fifo_burst_reader_if.slave bus
);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [LENBIT-1:0] remain_q;
  logic              first_q;
  logic              busy_q;
  logic              done_q;

  logic              vld_p1;
  logic [WIDTH-1:0]  dat_p1;
  logic              sop_p1;
  logic              eop_p1;

  logic              burst_go;
  logic              load;
  logic              last_pop;
  logic              accept;
  logic              last_beat;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (burst_go)  state_d = RUN;
      RUN:     if (last_pop)  state_d = DRAIN;
      DRAIN:   if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A pop is allowed only when the output register is empty or being emptied.
  always_comb begin
    burst_go  = 1'b0;
    load      = 1'b0;
    last_pop  = 1'b0;
    accept    = vld_p1 & bus.ordy;
    last_beat = accept & eop_p1;
    case (state_q)
      IDLE: begin
        burst_go = bus.start & (bus.burstlen != '0);
      end
      RUN: begin
        load     = bus.notempty & (~vld_p1 | bus.ordy);
        last_pop = load & (remain_q == LENBIT'(1));
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      remain_q <= '0;
      first_q  <= 1'b0;
    end else if (burst_go) begin
      remain_q <= bus.burstlen;
      first_q  <= 1'b1;
    end else if (load) begin
      remain_q <= remain_q - LENBIT'(1);
      first_q  <= 1'b0;
    end
  end

  // Stage p1: output register, refilled on the same edge it is drained.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      vld_p1 <= 1'b0;
      dat_p1 <= '0;
      sop_p1 <= 1'b0;
      eop_p1 <= 1'b0;
    end else if (load) begin
      vld_p1 <= 1'b1;
      dat_p1 <= bus.fifodout;
      sop_p1 <= first_q;
      eop_p1 <= (remain_q == LENBIT'(1));
    end else if (accept) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= (state_q == DRAIN) & last_beat;
    end
  end

  assign bus.fiford = load;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ovld   = vld_p1;
  assign bus.odat   = dat_p1;
  assign bus.osop   = sop_p1;
  assign bus.oeop   = eop_p1;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model, scoreboard of expected beats and
// a negedge monitor, with directed scenarios followed by random bursts.
module tb_fifo_burst_reader;
  import fifo_burst_pkg::*;

  localparam int W = 8;
  localparam int L = 8;

  typedef struct {
    int idx;
    bit sop;
    bit eop;
  } beat_t;

  logic clk = 1'b0;
  logic rst_ = 1'b0;

  fifo_burst_reader_if #(.WIDTH(W), .LENBIT(L)) bus();

  fifo_burst_reader #(.WIDTH(W), .LENBIT(L)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [W-1:0] fq[$];
  logic [W-1:0] pushed[$];
  beat_t      exp_q[$];
  beat_t      mb;
  int         ptr = 0;
  bit         pop_pend = 1'b0;
  int         ordy_mode = 0;
  int         ordy_ph = 0;
  int         beats_seen = 0;
  bit         exp_done = 1'b0;
  bit         stall_prev = 1'b0;
  logic [W-1:0] prev_dat;
  logic       prev_sop;
  logic       prev_eop;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    fq.push_back(d);
    pushed.push_back(d);
  endtask

  // FIFO model: show-ahead head word, pop applied after the edge that consumed it.
  initial begin
    bus.notempty = 1'b0;
    bus.fifodout = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pop_pend && rst_ && fq.size() != 0) void'(fq.pop_front());
      bus.notempty = (fq.size() != 0);
      bus.fifodout = (fq.size() != 0) ? fq[0] : '0;
    end
  end

  initial begin
    bus.ordy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ordy_mode)
        0: bus.ordy = 1'b1;
        1: begin
          bus.ordy = (ordy_ph % 3 == 0);
          ordy_ph++;
        end
        default: bus.ordy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_) begin
      exp_q.delete();
      exp_done   = 1'b0;
      stall_prev = 1'b0;
      pop_pend   = 1'b0;
    end else begin
      check(!(bus.fiford && !bus.notempty), "pop_when_empty", bus.fiford, 0);
      check(!(bus.ovld && !bus.ordy && bus.fiford), "pop_during_stall", bus.fiford, 0);
      if (stall_prev)
        check(bus.ovld === 1'b1 && bus.odat === prev_dat && bus.osop === prev_sop &&
              bus.oeop === prev_eop, "stall_hold", {bus.ovld, bus.osop, bus.oeop, bus.odat},
              {1'b1, prev_sop, prev_eop, prev_dat});
      check(bus.done === exp_done, "done", bus.done, exp_done);
      if (exp_done) check(bus.busy === 1'b0, "busy_fall", bus.busy, 0);
      exp_done = 1'b0;
      if (bus.ovld && bus.ordy) begin
        beats_seen++;
        check(exp_q.size() != 0, "unexpected_beat", bus.odat, 0);
        if (exp_q.size() != 0) begin
          mb = exp_q.pop_front();
          check(bus.odat === pushed[mb.idx] && bus.osop === mb.sop && bus.oeop === mb.eop,
                "beat", {bus.osop, bus.oeop, bus.odat}, {mb.sop, mb.eop, pushed[mb.idx]});
          if (mb.eop) exp_done = 1'b1;
        end
      end
      stall_prev = bus.ovld && !bus.ordy;
      prev_dat   = bus.odat;
      prev_sop   = bus.osop;
      prev_eop   = bus.oeop;
      pop_pend   = bus.fiford;
    end
  end

  // A start is honoured only when no burst is outstanding and the length is nonzero.
  task automatic issue_start(input int len);
    int sz;
    bit acc;
    @(posedge clk);
    #1;
    sz  = exp_q.size();
    acc = (sz == 0) && (len != 0);
    bus.start    = 1'b1;
    bus.burstlen = L'(len);
    if (acc) begin
      for (int i = 0; i < len; i++) exp_q.push_back('{ptr + i, i == 0, i == len - 1});
      ptr += len;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (acc) check(bus.busy === 1'b1, "busy_rise", bus.busy, 1);
    else if (sz == 0) check(bus.busy === 1'b0, "busy_stays_idle", bus.busy, 0);
    else if (sz >= 3) check(bus.busy === 1'b1, "busy_holds", bus.busy, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(exp_q.size() == 0, "burst_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fcnt, ffirst, flast, bcnt, bfirst, blast, base, n, len, pre;
    bus.start    = 1'b0;
    bus.burstlen = '0;
    rst_ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(bus.fiford === 1'b0, "rst_fiford", bus.fiford, 0);
    check(bus.busy === 1'b0, "rst_busy", bus.busy, 0);
    check(bus.done === 1'b0, "rst_done", bus.done, 0);
    check(bus.ovld === 1'b0, "rst_ovld", bus.ovld, 0);
    check(bus.odat === '0, "rst_odat", bus.odat, 0);
    check(bus.osop === 1'b0, "rst_osop", bus.osop, 0);
    check(bus.oeop === 1'b0, "rst_oeop", bus.oeop, 0);
    @(negedge clk);
    rst_ = 1'b1;

    // Preloaded 4-word burst at full rate.
    ordy_mode = 0;
    for (int i = 0; i < 4; i++) push_word(8'h10 + W'(i));
    repeat (2) @(posedge clk);
    issue_start(4);
    fcnt = 0; ffirst = -1; flast = -1; bcnt = 0; bfirst = -1; blast = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.fiford) begin
        fcnt++;
        if (ffirst < 0) ffirst = i;
        flast = i;
      end
      if (bus.ovld && bus.ordy) begin
        bcnt++;
        if (bfirst < 0) bfirst = i;
        blast = i;
      end
    end
    check(fcnt == 4 && flast - ffirst == 3 && ffirst == 0, "fiford_run", {fcnt, ffirst}, {32'd4, 32'd0});
    check(bcnt == 4 && blast - bfirst == 3 && bfirst == 1, "beat_run", {bcnt, bfirst}, {32'd4, 32'd1});
    wait_idle(100);

    // Same burst with ordy pattern 1,0,0,...
    for (int i = 0; i < 4; i++) push_word(8'h20 + W'(i));
    ordy_mode = 1;
    ordy_ph = 0;
    issue_start(4);
    wait_idle(200);

    // FIFO runs dry mid-burst and refills later.
    ordy_mode = 0;
    push_word(8'h30);
    push_word(8'h31);
    issue_start(5);
    repeat (6) @(posedge clk);
    #1;
    check(bus.busy === 1'b1 && bus.fiford === 1'b0 && bus.ovld === 1'b0, "starved_wait",
          {bus.busy, bus.fiford, bus.ovld}, 3'b100);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) push_word(8'h32 + W'(i));
    wait_idle(100);

    // Single-word burst.
    push_word(8'hA5);
    issue_start(1);
    wait_idle(100);

    // Zero-length start and a start during a burst are both ignored.
    issue_start(0);
    repeat (4) @(posedge clk);
    for (int i = 0; i < 8; i++) push_word(8'h40 + W'(i));
    ordy_mode = 1;
    ordy_ph = 0;
    issue_start(8);
    repeat (2) @(posedge clk);
    issue_start(3);
    wait_idle(300);

    // Asynchronous reset after two of six beats.
    ordy_mode = 0;
    for (int i = 0; i < 6; i++) push_word(8'h50 + W'(i));
    issue_start(6);
    base = beats_seen;
    n = 0;
    while (beats_seen < base + 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check(beats_seen >= base + 2, "reset_setup", beats_seen - base, 2);
    #2;
    rst_ = 1'b0;
    #1;
    check(bus.ovld === 1'b0 && bus.odat === '0 && bus.osop === 1'b0 && bus.oeop === 1'b0,
          "async_rst_out", {bus.ovld, bus.osop, bus.oeop, bus.odat}, 0);
    check(bus.busy === 1'b0 && bus.done === 1'b0 && bus.fiford === 1'b0,
          "async_rst_ctl", {bus.busy, bus.done, bus.fiford}, 0);
    @(negedge clk);
    #2;
    rst_ = 1'b1;
    ptr = pushed.size() - fq.size();
    repeat (2) @(posedge clk);
    issue_start(2);
    wait_idle(100);

    // Random bursts with random refill timing and backpressure.
    for (int k = 0; k < 25; k++) begin
      len = $urandom_range(1, 12);
      pre = $urandom_range(0, len);
      for (int i = 0; i < pre; i++) push_word(W'($urandom));
      ordy_mode = $urandom_range(0, 2);
      issue_start(len);
      for (int i = pre; i < len; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        push_word(W'($urandom));
        if ($urandom_range(0, 5) == 0 && exp_q.size() >= 3) issue_start($urandom_range(0, 5));
      end
      wait_idle(400);
    end

    check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
